// File: rtl/axis_axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_axi_pkg -- capture/read state encodings and AXI burst constants  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package axis_axi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_t;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] OKAY  = 2'b00;

endpackage
`default_nettype wire

// File: rtl/axis_axi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_axi_if -- AXI-Stream input and AXI4 read channel bundle          |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface axis_axi_if #(
  parameter int G_AXI_DATAWIDTH  = 32,
  parameter int G_AXIS_DATAWIDTH = 24,
  parameter int G_MEMDEPTH       = 1024,
  parameter int G_ID_WIDTH       = 4
);
  localparam int AW = $clog2(G_MEMDEPTH * G_AXI_DATAWIDTH / 8);

  logic [G_AXIS_DATAWIDTH-1:0] s_axis_tdata;
  logic                        s_axis_tvalid;
  logic                        s_axis_tlast;
  logic                        s_axis_tready;

  logic [G_ID_WIDTH-1:0]       s_axi_arid;
  logic [AW-1:0]               s_axi_araddr;
  logic [7:0]                  s_axi_arlen;
  logic [2:0]                  s_axi_arsize;
  logic [1:0]                  s_axi_arburst;
  logic                        s_axi_arvalid;
  logic                        s_axi_arready;

  logic [G_ID_WIDTH-1:0]       s_axi_rid;
  logic [G_AXI_DATAWIDTH-1:0]  s_axi_rdata;
  logic [1:0]                  s_axi_rresp;
  logic                        s_axi_rlast;
  logic                        s_axi_rvalid;
  logic                        s_axi_rready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );
endinterface
`default_nettype wire

// File: rtl/axis_axi_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_axi_ram -- simple dual-port buffer, read-first, 1-cycle read     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module axis_axi_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [WIDTH-1:0]  wdata,
  input  wire logic              re,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; re=0 holds it so a stalled beat stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_axi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_axi -- capture one AXI-Stream frame, serve it over AXI4 reads    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module axis_axi
  import axis_axi_pkg::*;
#(
  parameter int G_AXI_DATAWIDTH  = 32,
  parameter int G_AXIS_DATAWIDTH = 24,
  parameter int G_MEMDEPTH       = 1024,
  parameter int G_ID_WIDTH       = 4
) (
  input  wire logic                      s_aclk,
  input  wire logic                      s_areset,
  axis_axi_if.slave                      bus,
  input  wire logic                      cap_arm,
  output logic                           cap_busy,
  output logic                           cap_done,
  output logic                           cap_overflow,
  output logic [$clog2(G_MEMDEPTH):0]    cap_count
);

  localparam int MW     = $clog2(G_MEMDEPTH);
  localparam int CW     = MW + 1;
  localparam int BSHIFT = $clog2(G_AXI_DATAWIDTH / 8);

  cap_state_t                 cap_state;
  logic                       tready_q;
  logic                       wr_en;
  logic [G_AXI_DATAWIDTH-1:0] wr_data;

  rd_state_t                  rd_state;
  logic                       arready_q;
  logic                       rvalid_q;
  logic                       rlast_q;
  logic [G_ID_WIDTH-1:0]      rid_q;
  logic [MW-1:0]              rd_addr;
  logic [8:0]                 remain;
  logic                       advance;
  logic                       wait_q;
  logic                       rd_en;
  logic                       unused_arsize;

  assign wr_en   = bus.s_axis_tvalid & tready_q;
  assign wr_data = G_AXI_DATAWIDTH'(bus.s_axis_tdata);

  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      cap_state    <= IDLE;
      tready_q     <= 1'b0;
      cap_busy     <= 1'b0;
      cap_done     <= 1'b0;
      cap_overflow <= 1'b0;
      cap_count    <= '0;
    end else begin
      case (cap_state)
        IDLE, DONE: begin
          if (cap_arm) begin
            cap_state    <= CAPTURE;
            tready_q     <= 1'b1;
            cap_busy     <= 1'b1;
            cap_done     <= 1'b0;
            cap_overflow <= 1'b0;
            cap_count    <= '0;
          end
        end
        CAPTURE: begin
          if (wr_en) begin
            cap_count <= cap_count + 1'b1;
            if (bus.s_axis_tlast) begin
              cap_state <= DONE;
              tready_q  <= 1'b0;
              cap_busy  <= 1'b0;
              cap_done  <= 1'b1;
            end else if (cap_count == CW'(G_MEMDEPTH - 1)) begin
              cap_state    <= DONE;
              tready_q     <= 1'b0;
              cap_busy     <= 1'b0;
              cap_overflow <= 1'b1;
            end
          end
        end
        default: begin
          cap_state <= IDLE;
          tready_q  <= 1'b0;
          cap_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch the next word whenever the output slot is free or being drained;
  // the one-cycle wait after AR gives the 2-cycle first-beat latency.
  assign rd_en = (rd_state == R_BURST) && !wait_q && (remain != 9'd0)
                 && (!rvalid_q || bus.s_axi_rready);

  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rd_addr   <= '0;
      remain    <= '0;
      advance   <= 1'b0;
      wait_q    <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (bus.s_axi_arvalid && arready_q) begin
            rd_state  <= R_BURST;
            arready_q <= 1'b0;
            rid_q     <= bus.s_axi_arid;
            rd_addr   <= MW'(bus.s_axi_araddr >> BSHIFT);
            remain    <= 9'(bus.s_axi_arlen) + 9'd1;
            wait_q    <= 1'b1;
            case (bus.s_axi_arburst)
              FIXED:       advance <= 1'b0;
              INCR, WRAP:  advance <= 1'b1;
              default:     advance <= 1'b1;
            endcase
          end
        end
        R_BURST: begin
          wait_q <= 1'b0;
          if (rd_en) begin
            remain   <= remain - 9'd1;
            rvalid_q <= 1'b1;
            rlast_q  <= (remain == 9'd1);
            if (advance) begin
              rd_addr <= rd_addr + 1'b1;
            end
          end else if (rvalid_q && bus.s_axi_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
          end
          if (rvalid_q && bus.s_axi_rready && rlast_q) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b1;
          end
        end
        default: begin
          rd_state  <= R_IDLE;
          arready_q <= 1'b0;
        end
      endcase
    end
  end

  axis_axi_ram #(
    .WIDTH (G_AXI_DATAWIDTH),
    .DEPTH (G_MEMDEPTH)
  ) u_ram (
    .clk   (s_aclk),
    .rst   (s_areset),
    .we    (wr_en),
    .waddr (cap_count[MW-1:0]),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (bus.s_axi_rdata)
  );

  assign bus.s_axis_tready = tready_q;
  assign bus.s_axi_arready = arready_q;
  assign bus.s_axi_rvalid  = rvalid_q;
  assign bus.s_axi_rlast   = rlast_q;
  assign bus.s_axi_rid     = rid_q;
  assign bus.s_axi_rresp   = OKAY;
  assign unused_arsize     = ^bus.s_axi_arsize;

endmodule
`default_nettype wire

// File: tb/tb_axis_axi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_axi -- directed capture/read sequence with read scoreboard    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_axis_axi;
  import axis_axi_pkg::*;

  localparam int DW    = 32;
  localparam int SW    = 24;
  localparam int DEPTH = 1024;
  localparam int IDW   = 4;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic           last;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     cap_arm = 1'b0;
  logic                     cap_busy;
  logic                     cap_done;
  logic                     cap_overflow;
  logic [$clog2(DEPTH):0]   cap_count;

  logic [DW-1:0] model [DEPTH];
  beat_t         sb [$];
  int            exp_count = 0;
  int            n_checks  = 0;
  int            n_fail    = 0;

  always #5 clk = ~clk;

  axis_axi_if #(
    .G_AXI_DATAWIDTH (DW), .G_AXIS_DATAWIDTH (SW),
    .G_MEMDEPTH (DEPTH), .G_ID_WIDTH (IDW)
  ) bus ();

  axis_axi #(
    .G_AXI_DATAWIDTH (DW), .G_AXIS_DATAWIDTH (SW),
    .G_MEMDEPTH (DEPTH), .G_ID_WIDTH (IDW)
  ) dut (
    .s_aclk       (clk),
    .s_areset     (rst),
    .bus          (bus),
    .cap_arm      (cap_arm),
    .cap_busy     (cap_busy),
    .cap_done     (cap_done),
    .cap_overflow (cap_overflow),
    .cap_count    (cap_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic arm();
    @(negedge clk);
    cap_arm = 1'b1;
    @(negedge clk);
    cap_arm   = 1'b0;
    exp_count = 0;
  endtask

  // Called at a negedge; a beat presented while tready=1 is taken at the next posedge.
  task automatic send_beats(input int n, input logic [SW-1:0] seed, input bit with_last);
    logic [SW-1:0] d;
    int t;
    for (int i = 0; i < n; i++) begin
      d = seed + SW'(i);
      bus.s_axis_tdata  = d;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tlast  = with_last && (i == n - 1);
      t = 0;
      while (bus.s_axis_tready !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) begin
        timeout("tready_wait");
        break;
      end
      model[exp_count] = DW'(d);
      exp_count++;
      @(negedge clk);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic read_burst(input logic [IDW-1:0] id, input logic [11:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input bit rand_ready, input int stop_after, input bit check_lat);
    int w;
    int t;
    int beats;
    bit stalled;
    logic [DW-1:0] held_data;
    logic held_last;
    beat_t e;
    w = int'(addr >> 2);
    for (int b = 0; b <= int'(len); b++) begin
      sb.push_back('{id: id, data: model[w], last: (b == int'(len))});
      if (burst != FIXED) w = (w + 1) % DEPTH;
    end
    @(negedge clk);
    bus.s_axi_arid    = id;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arlen   = len;
    bus.s_axi_arburst = burst;
    bus.s_axi_arsize  = 3'd2;
    bus.s_axi_arvalid = 1'b1;
    t = 0;
    while (bus.s_axi_arready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) timeout("arready_wait");
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b1;
    if (check_lat) begin
      @(negedge clk);
      check("rvalid_1cyc", 64'(bus.s_axi_rvalid), 64'd0);
      @(negedge clk);
      check("rvalid_2cyc", 64'(bus.s_axi_rvalid), 64'd1);
    end
    beats = 0;
    stalled = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    t = 0;
    while (t < 200) begin
      if (beats == int'(len) + 1 || (stop_after > 0 && beats >= stop_after)) break;
      bus.s_axi_rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.s_axi_rvalid === 1'b1) begin
        if (stalled) begin
          check("hold_rdata", 64'(bus.s_axi_rdata), 64'(held_data));
          check("hold_rlast", 64'(bus.s_axi_rlast), 64'(held_last));
        end
        if (bus.s_axi_rready) begin
          e = sb.pop_front();
          check("rdata", 64'(bus.s_axi_rdata), 64'(e.data));
          check("rlast", 64'(bus.s_axi_rlast), 64'(e.last));
          check("rid",   64'(bus.s_axi_rid),   64'(e.id));
          check("rresp", 64'(bus.s_axi_rresp), 64'(OKAY));
          beats++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_data = bus.s_axi_rdata;
          held_last = bus.s_axi_rlast;
        end
      end
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout("rbeat_wait");
    bus.s_axi_rready = 1'b0;
    if (stop_after == 0) begin
      check("rvalid_after", 64'(bus.s_axi_rvalid), 64'd0);
      check("arready_after", 64'(bus.s_axi_arready), 64'd1);
    end
  endtask

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axi_arid    = '0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arlen   = '0;
    bus.s_axi_arsize  = '0;
    bus.s_axi_arburst = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tready",  64'(bus.s_axis_tready), 64'd0);
    check("rst_arready", 64'(bus.s_axi_arready), 64'd0);
    check("rst_rvalid",  64'(bus.s_axi_rvalid),  64'd0);
    check("rst_rdata",   64'(bus.s_axi_rdata),   64'd0);
    check("rst_count",   64'(cap_count),         64'd0);
    check("rst_busy",    64'(cap_busy),          64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("arready_up", 64'(bus.s_axi_arready), 64'd1);

    // Five-beat frame, then INCR read of it
    arm();
    check("arm_busy",   64'(cap_busy),          64'd1);
    check("arm_tready", 64'(bus.s_axis_tready), 64'd1);
    send_beats(5, 24'h000001, 1'b1);
    check("frame_done",   64'(cap_done),          64'd1);
    check("frame_count",  64'(cap_count),         64'd5);
    check("frame_busy",   64'(cap_busy),          64'd0);
    check("frame_tready", 64'(bus.s_axis_tready), 64'd0);
    read_burst(4'h1, 12'h000, 8'd4, INCR, 1'b0, 0, 1'b1);

    // Overflow: full buffer without tlast, extra beat refused
    arm();
    send_beats(DEPTH, 24'h000100, 1'b0);
    check("ovf_flag",   64'(cap_overflow),      64'd1);
    check("ovf_count",  64'(cap_count),         64'(DEPTH));
    check("ovf_tready", 64'(bus.s_axis_tready), 64'd0);
    bus.s_axis_tdata  = 24'hABCDEF;
    bus.s_axis_tvalid = 1'b1;
    repeat (4) @(negedge clk);
    check("ovf_count_hold",  64'(cap_count),         64'(DEPTH));
    check("ovf_tready_hold", 64'(bus.s_axis_tready), 64'd0);
    bus.s_axis_tvalid = 1'b0;

    // FIXED, wrap-around INCR, WRAP and stalled INCR bursts
    read_burst(4'hA, 12'h008, 8'd3,  FIXED, 1'b0, 0, 1'b1);
    read_burst(4'h2, 12'hFFC, 8'd1,  INCR,  1'b0, 0, 1'b0);
    read_burst(4'h3, 12'hFF8, 8'd3,  WRAP,  1'b0, 0, 1'b0);
    read_burst(4'h6, 12'h100, 8'd15, INCR,  1'b1, 0, 1'b0);

    // Reset in the middle of a capture and a burst
    arm();
    send_beats(3, 24'h777000, 1'b0);
    check("mid_count", 64'(cap_count), 64'd3);
    read_burst(4'h5, 12'h000, 8'd7, INCR, 1'b0, 2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    check("mrst_tready",  64'(bus.s_axis_tready), 64'd0);
    check("mrst_busy",    64'(cap_busy),          64'd0);
    check("mrst_done",    64'(cap_done),          64'd0);
    check("mrst_ovf",     64'(cap_overflow),      64'd0);
    check("mrst_count",   64'(cap_count),         64'd0);
    check("mrst_arready", 64'(bus.s_axi_arready), 64'd0);
    check("mrst_rvalid",  64'(bus.s_axi_rvalid),  64'd0);
    check("mrst_rlast",   64'(bus.s_axi_rlast),   64'd0);
    check("mrst_rid",     64'(bus.s_axi_rid),     64'd0);
    check("mrst_rresp",   64'(bus.s_axi_rresp),   64'd0);
    check("mrst_rdata",   64'(bus.s_axi_rdata),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_arready_up", 64'(bus.s_axi_arready), 64'd1);
    read_burst(4'h3, 12'h000, 8'd2, INCR, 1'b0, 0, 1'b0);
    arm();
    check("rearm_count", 64'(cap_count), 64'd0);
    check("rearm_busy",  64'(cap_busy),  64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
